// File: rtl/imem_responder.sv
// Multi-cycle instruction memory behind the PC register: holds fetch with Stall for a
// fixed latency, then presents the word with a one-cycle Done pulse.
module imem_responder #(
    parameter int LATENCY    = 4,
    parameter int DEPTH_LOG2 = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic        Rd,
    input  logic        Flush,
    input  logic        LdEn,
    input  logic [15:0] LdAddr,
    input  logic [15:0] LdData,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        Err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] areq_q, areq_d;
    logic                  mis_q, mis_d;
    logic [15:0]           data_out_q, data_out_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic [15:0] mem [DEPTH];

    // Address bits above the array and the byte bit of the load address select nothing.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{Addr[15:DEPTH_LOG2+1], LdAddr[15:DEPTH_LOG2+1], LdAddr[0]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        areq_d     = areq_q;
        mis_d      = mis_q;
        data_out_d = data_out_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (Rd && !Flush) begin
                    state_d = S_BUSY;
                    areq_d  = Addr[DEPTH_LOG2:1];
                    mis_d   = Addr[0];
                    cnt_d   = 4'(LATENCY - 2);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (Flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Combinational array read here gives read-before-write against a same-edge load.
                    state_d    = S_DONE;
                    done_d     = 1'b1;
                    err_d      = mis_q;
                    data_out_d = mis_q ? 16'h0000 : mem[areq_q];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            areq_q     <= '0;
            mis_q      <= 1'b0;
            data_out_q <= 16'h0000;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            areq_q     <= areq_d;
            mis_q      <= mis_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Program contents survive reset.
    always_ff @(posedge clk) begin
        if (LdEn) begin
            mem[LdAddr[DEPTH_LOG2:1]] <= LdData;
        end
    end

    assign Stall   = (state_q == S_BUSY);
    assign Done    = done_q;
    assign Err     = err_q;
    assign DataOut = data_out_q;

endmodule

// File: doc/imem_responder.md
# imem_responder

Multi-cycle instruction-memory responder that serves the fetch stage's read requests over a Rd/Stall/Done handshake. It replaces the single-cycle instruction memory behind the PC register and stalls fetch for a fixed, parameterized latency. It also honours branch-redirect flushes, flags misaligned requests, and exposes a backdoor load port for program preload. Its contents are word-organized, and it sits between the PC register and the IF/ID pipeline register.

## Interface
- LATENCY, 4: cycles from request acceptance to Done; legal range 2..15.
- DEPTH_LOG2, 13: log2 of the number of 16-bit words stored.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- Addr  input  16  byte address of the instruction to fetch.
- Rd  input  1  read request; sampled only when accepting.
- Flush  input  1  branch redirect; aborts any in-flight request.
- LdEn  input  1  backdoor write enable.
- LdAddr  input  16  backdoor byte address.
- LdData  input  16  backdoor write data.
- DataOut  output  16  fetched instruction; registered.
- Done  output  1  one-cycle pulse; DataOut/Err are valid this cycle.
- Stall  output  1  responder busy; fetch must hold PC and Addr.
- Err  output  1  misaligned-address flag; qualified by Done.

## Operation
- Storage: 2^DEPTH_LOG2 x 16 array, indexed by Addr[DEPTH_LOG2:1]. Upper address bits are ignored, so addresses wrap modulo depth. Contents are not cleared by reset.
- States: IDLE, BUSY, DONE, with a 4-bit down-counter cnt.
- Accepting: the block accepts a request when in IDLE or DONE with Rd=1 and Flush=0. It then latches Addr into areq and loads cnt=LATENCY-2.
  - If Addr[0]=0: go to BUSY.
  - If Addr[0]=1: go to BUSY with an error flag latched.
- BUSY:
  - Stall=1; Rd is ignored.
  - While cnt!=0, cnt decrements.
  - When cnt==0: go to DONE, registering DataOut=mem[areq] (or 16'h0000 with Err=1 if misaligned).
- DONE:
  - Done=1 and Stall=0 for exactly one cycle.
  - A new accept is allowed in this same cycle (back-to-back). Otherwise the next state is IDLE.
- Flush:
  - In BUSY: return to IDLE next edge, with no Done and DataOut unchanged.
  - In IDLE or DONE: suppresses acceptance of any simultaneous Rd. A Done already being presented still completes.
- Backdoor: when LdEn=1, mem[LdAddr[DEPTH_LOG2:1]] <= LdData on the edge, in any state.
  - On a same-edge collision with the DataOut capture, the read returns the old word (read-before-write).
  - A write during BUSY to areq's word that lands before the capture edge is visible in DataOut.
- Err, Done and DataOut hold their last value outside Done cycles, except that Done and Err deassert.

## Timing
- Reset (async) forces state=IDLE, cnt=0, DataOut=16'h0000, Done=0, Err=0, Stall=0. Any in-flight request is lost.
- Request sampled at the edge ending cycle T:
  - Stall=1 in cycles T+1..T+LATENCY-1.
  - Done=1 in cycle T+LATENCY.
- Stall is a combinational decode of state==BUSY. Stall is 0 in the request cycle T itself; fetch relies on Done, not on the absence of Stall, for data.
- Maximum throughput is one instruction per LATENCY cycles, with no idle bubble between back-to-back requests.
- Rd held high continuously issues a new request in every DONE cycle.

## Test plan
- Preload mem[0x0010>>1]=16'hA5C3 via LdEn; Rd=1 with Addr=16'h0010 at T → Stall=1 for T+1..T+3; Done=1, DataOut=16'hA5C3, Err=0 at T+4 (LATENCY=4).
- Rd held high with Addr=0x0000 then 0x0002 (mem 16'h1111, 16'h2222) → Done pulses at T+4 and T+8 with DataOut 16'h1111 then 16'h2222; no idle cycle between them.
- Request Addr=0x0020, assert Flush at T+2 → state IDLE at T+3; no Done through T+8; DataOut keeps its prior value.
- Rd with Addr=16'h0013 → Done=1, Err=1, DataOut=16'h0000 at T+4; next aligned request returns Err=0.
- Addr=16'h4010 with DEPTH_LOG2=13 → returns mem word 0x0008 (wrap); backdoor write to the same word on the capture edge → old data returned.
- Assert rst asynchronously mid-BUSY (T+2) → Stall, Done, Err and DataOut go to 0 immediately; no Done follows; the next Rd completes normally after LATENCY cycles.
